// File: rtl/dplbuf_link_pkg.sv
// dplbuf_link_pkg
// Shared constants for the per-link responder of the DPL-buffer MM decoder:
// register offsets (decoded on iADDR[9:0]), CTRL/STATUS bit positions, the
// tags returned by the ID register and by unmapped offsets, and an address
// decode helper that maps an offset onto a register select.
package dplbuf_link_pkg;

  localparam int ADDR_DEC_W = 10;

  localparam logic [ADDR_DEC_W-1:0] OFF_CTRL      = 10'h000;
  localparam logic [ADDR_DEC_W-1:0] OFF_STATUS    = 10'h001;
  localparam logic [ADDR_DEC_W-1:0] OFF_OVF_CNT   = 10'h002;
  localparam logic [ADDR_DEC_W-1:0] OFF_SCRATCH   = 10'h003;
  localparam logic [ADDR_DEC_W-1:0] OFF_ID        = 10'h004;
  localparam logic [ADDR_DEC_W-1:0] OFF_FIFO_DATA = 10'h010;

  localparam int CTRL_ENABLE_BIT = 0;
  localparam int CTRL_FLUSH_BIT  = 1;
  localparam int CTRL_THRESH_LSB = 8;
  localparam int CTRL_THRESH_W   = 8;

  localparam int STAT_LEVEL_LSB = 0;
  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVF_BIT   = 16;
  localparam int STAT_UDF_BIT   = 17;

  localparam logic [31:0] ID_TAG       = 32'h5555_AAAA;
  localparam logic [31:0] UNMAPPED_TAG = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    REG_CTRL,
    REG_STATUS,
    REG_OVF_CNT,
    REG_SCRATCH,
    REG_ID,
    REG_FIFO,
    REG_UNMAPPED
  } reg_sel_e;

  function automatic reg_sel_e decode_addr(input logic [ADDR_DEC_W-1:0] off);
    reg_sel_e sel;
    case (off)
      OFF_CTRL:      sel = REG_CTRL;
      OFF_STATUS:    sel = REG_STATUS;
      OFF_OVF_CNT:   sel = REG_OVF_CNT;
      OFF_SCRATCH:   sel = REG_SCRATCH;
      OFF_ID:        sel = REG_ID;
      OFF_FIFO_DATA: sel = REG_FIFO;
      default:       sel = REG_UNMAPPED;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/dplbuf_link_responder_if.sv
// dplbuf_link_responder_if
// Bundles the MM request/response signals and the link-side push signals
// that reach one link responder.
//   master : decoder/link side (drives addr, strobes, write data, push data)
//   slave  : responder side (returns rd_data / rd_data_v)
// Handshake: there is no backpressure. wr_en and rd_en are single-cycle
// strobes qualified by addr; every rd_en is answered by exactly one
// rd_data_v pulse on the following cycle, and rd_data stays stable after
// that pulse until the next response. dat_v is a single-cycle push strobe
// qualified by dat; the responder accepts or drops it in the same cycle.
interface dplbuf_link_responder_if;
  logic [13:0] addr;
  logic        wr_en;
  logic        rd_en;
  logic [63:0] wr_data;
  logic [63:0] rd_data;
  logic        rd_data_v;
  logic        dat_v;
  logic [63:0] dat;

  modport master (
    output addr, wr_en, rd_en, wr_data, dat_v, dat,
    input  rd_data, rd_data_v
  );

  modport slave (
    input  addr, wr_en, rd_en, wr_data, dat_v, dat,
    output rd_data, rd_data_v
  );
endinterface

// File: rtl/dplbuf_sync_fifo.sv
// dplbuf_sync_fifo
// Single-clock FIFO, depth 2**FIFO_AW, DW-bit entries.
//   push/push_data : write request; accepted when not full, or when full and
//                    a pop is accepted in the same cycle
//   pop            : read request; ignored when empty
//   flush          : clears both pointers; any push/pop that cycle is lost
//   head_data      : current head entry (0 when empty), read combinationally
//   level/full/empty : occupancy derived from (FIFO_AW+1)-bit pointers
module dplbuf_sync_fifo #(
  parameter int FIFO_AW = 4,
  parameter int DW      = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [DW-1:0]    push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [DW-1:0]    head_data,
  output logic [FIFO_AW:0] level,
  output logic             full,
  output logic             empty
);

  localparam int                 DEPTH   = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_L = (FIFO_AW + 1)'(DEPTH);

  logic [DW-1:0]    mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic             pop_ok;
  logic             push_ok;

  // The extra pointer bit distinguishes full from empty when the low bits match.
  assign level   = wr_ptr_q - rd_ptr_q;
  assign empty   = (level == '0);
  assign full    = (level == DEPTH_L);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_data = empty ? '0 : mem_q[rd_ptr_q[FIFO_AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only visible once the pointers cover it.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/dplbuf_link_responder.sv
// dplbuf_link_responder
// Link-side responder of the DPL-buffer MM decoder (one instance per link).
// Holds CTRL/STATUS/OVF_CNT/SCRATCH/ID registers and a receive FIFO that the
// link datapath fills (iDAT_V/iDAT) and MM reads of FIFO_DATA drain.
//   clk, rst_n        : core clock, asynchronous active-low reset
//   iADDR             : MM word address, [9:0] decoded
//   iWR_EN/iWR_DATA   : single-cycle MM write
//   iRD_EN            : single-cycle MM read
//   oRD_DATA/_V       : registered read response, valid one cycle after iRD_EN,
//                       data held until the next response
//   iDAT_V/iDAT       : link-side push into the FIFO
//   oENABLE           : CTRL.enable
//   oFLUSH            : one-cycle pulse after a CTRL write with flush set
//   oTHRESH_HIT       : registered, FIFO level >= CTRL.thresh (thresh != 0)
module dplbuf_link_responder
  import dplbuf_link_pkg::*;
#(
  parameter int LINK_ID = 0,
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] iADDR,
  input  logic        iWR_EN,
  input  logic        iRD_EN,
  input  logic [63:0] iWR_DATA,
  output logic [63:0] oRD_DATA,
  output logic        oRD_DATA_V,
  input  logic        iDAT_V,
  input  logic [63:0] iDAT,
  output logic        oENABLE,
  output logic        oFLUSH,
  output logic        oTHRESH_HIT
);

  localparam logic [3:0] LINK_ID_4 = 4'(LINK_ID);

  reg_sel_e sel;

  logic        ctrl_enable_q, ctrl_enable_d;
  logic [7:0]  ctrl_thresh_q, ctrl_thresh_d;
  logic        flush_q, flush_d;
  logic [63:0] scratch_q, scratch_d;
  logic [31:0] ovf_cnt_q, ovf_cnt_d;
  logic        ovf_sticky_q, ovf_sticky_d;
  logic        udf_sticky_q, udf_sticky_d;
  logic [63:0] rd_data_q, rd_data_d;
  logic        rd_data_v_q, rd_data_v_d;
  logic        thresh_hit_q, thresh_hit_d;

  logic             wr_ctrl, wr_status, wr_ovf_cnt, wr_scratch;
  logic             flush_now;
  logic             push_req;
  logic             fifo_pop;
  logic             pop_ok;
  logic             ovf_event;
  logic             udf_event;
  logic [63:0]      rd_val;
  logic [63:0]      fifo_head;
  logic [FIFO_AW:0] fifo_level;
  logic             fifo_full;
  logic             fifo_empty;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^iADDR[13:10];

  assign sel        = decode_addr(iADDR[ADDR_DEC_W-1:0]);
  assign wr_ctrl    = iWR_EN && (sel == REG_CTRL);
  assign wr_status  = iWR_EN && (sel == REG_STATUS);
  assign wr_ovf_cnt = iWR_EN && (sel == REG_OVF_CNT);
  assign wr_scratch = iWR_EN && (sel == REG_SCRATCH);
  assign flush_now  = wr_ctrl && iWR_DATA[CTRL_FLUSH_BIT];
  assign fifo_pop   = iRD_EN && (sel == REG_FIFO);
  assign pop_ok     = fifo_pop && !fifo_empty;

  // Pushes are gated by the enable bit as it stands before any same-cycle write.
  assign push_req  = iDAT_V && ctrl_enable_q;
  // A push lost to a flush is a discard, not an overflow.
  assign ovf_event = push_req && !flush_now && fifo_full && !pop_ok;
  assign udf_event = fifo_pop && fifo_empty;

  dplbuf_sync_fifo #(
    .FIFO_AW (FIFO_AW),
    .DW      (64)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_req),
    .push_data (iDAT),
    .pop       (fifo_pop),
    .flush     (flush_now),
    .head_data (fifo_head),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Read mux sees only pre-write state, so a same-cycle write is not visible.
  always_comb begin
    rd_val = '0;
    unique case (sel)
      REG_CTRL: begin
        rd_val[CTRL_ENABLE_BIT]                  = ctrl_enable_q;
        rd_val[CTRL_THRESH_LSB +: CTRL_THRESH_W] = ctrl_thresh_q;
      end
      REG_STATUS: begin
        rd_val[STAT_LEVEL_LSB +: FIFO_AW+1] = fifo_level;
        rd_val[STAT_EMPTY_BIT]              = fifo_empty;
        rd_val[STAT_FULL_BIT]               = fifo_full;
        rd_val[STAT_OVF_BIT]                = ovf_sticky_q;
        rd_val[STAT_UDF_BIT]                = udf_sticky_q;
      end
      REG_OVF_CNT: rd_val = {32'h0, ovf_cnt_q};
      REG_SCRATCH: rd_val = scratch_q;
      REG_ID:      rd_val = {ID_TAG, 28'h0, LINK_ID_4};
      REG_FIFO:    rd_val = fifo_head;
      default:     rd_val = {UNMAPPED_TAG, 22'h0, iADDR[ADDR_DEC_W-1:0]};
    endcase
  end

  always_comb begin
    ctrl_enable_d = ctrl_enable_q;
    ctrl_thresh_d = ctrl_thresh_q;
    scratch_d     = scratch_q;
    ovf_cnt_d     = ovf_cnt_q;
    flush_d       = flush_now;
    rd_data_v_d   = iRD_EN;
    rd_data_d     = iRD_EN ? rd_val : rd_data_q;
    // Level is registered, so this flop lags a level change by one cycle.
    thresh_hit_d  = (ctrl_thresh_q != 8'h0) && (8'(fifo_level) >= ctrl_thresh_q);

    if (wr_ctrl) begin
      ctrl_enable_d = iWR_DATA[CTRL_ENABLE_BIT];
      ctrl_thresh_d = iWR_DATA[CTRL_THRESH_LSB +: CTRL_THRESH_W];
    end
    if (wr_scratch) scratch_d = iWR_DATA;

    // A clearing write takes priority over a same-cycle increment; the
    // counter saturates rather than wrapping.
    if (wr_ovf_cnt)                            ovf_cnt_d = '0;
    else if (ovf_event && (ovf_cnt_q != '1))   ovf_cnt_d = ovf_cnt_q + 32'd1;

    // W1C first, then set, so a concurrent new event wins.
    ovf_sticky_d = (ovf_sticky_q && !(wr_status && iWR_DATA[STAT_OVF_BIT])) || ovf_event;
    udf_sticky_d = (udf_sticky_q && !(wr_status && iWR_DATA[STAT_UDF_BIT])) || udf_event;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_enable_q <= 1'b0;
      ctrl_thresh_q <= '0;
      flush_q       <= 1'b0;
      scratch_q     <= '0;
      ovf_cnt_q     <= '0;
      ovf_sticky_q  <= 1'b0;
      udf_sticky_q  <= 1'b0;
      rd_data_q     <= '0;
      rd_data_v_q   <= 1'b0;
      thresh_hit_q  <= 1'b0;
    end else begin
      ctrl_enable_q <= ctrl_enable_d;
      ctrl_thresh_q <= ctrl_thresh_d;
      flush_q       <= flush_d;
      scratch_q     <= scratch_d;
      ovf_cnt_q     <= ovf_cnt_d;
      ovf_sticky_q  <= ovf_sticky_d;
      udf_sticky_q  <= udf_sticky_d;
      rd_data_q     <= rd_data_d;
      rd_data_v_q   <= rd_data_v_d;
      thresh_hit_q  <= thresh_hit_d;
    end
  end

  assign oRD_DATA    = rd_data_q;
  assign oRD_DATA_V  = rd_data_v_q;
  assign oENABLE     = ctrl_enable_q;
  assign oFLUSH      = flush_q;
  assign oTHRESH_HIT = thresh_hit_q;

endmodule

// File: tb/tb_dplbuf_link_responder.sv
module tb_dplbuf_link_responder;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dplbuf_link_responder_if bus ();
  logic enable_o, flush_o, thresh_hit_o;

  dplbuf_link_responder #(.LINK_ID(7), .FIFO_AW(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iADDR       (bus.addr),
    .iWR_EN      (bus.wr_en),
    .iRD_EN      (bus.rd_en),
    .iWR_DATA    (bus.wr_data),
    .oRD_DATA    (bus.rd_data),
    .oRD_DATA_V  (bus.rd_data_v),
    .iDAT_V      (bus.dat_v),
    .iDAT        (bus.dat),
    .oENABLE     (enable_o),
    .oFLUSH      (flush_o),
    .oTHRESH_HIT (thresh_hit_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] fifo_m [$];
  logic [63:0] exp_q [$];
  bit          m_enable   = 0;
  logic [7:0]  m_thresh   = 0;
  logic [63:0] m_scratch  = 0;
  logic [31:0] m_ovf_cnt  = 0;
  bit          m_ovf      = 0;
  bit          m_udf      = 0;
  bit          m_exp_rd_v = 0;
  bit          m_exp_fl   = 0;
  bit          m_exp_th   = 0;
  logic [63:0] exp_hold   = 0;

  function automatic logic [63:0] m_status();
    logic [4:0] lvl;
    lvl = 5'(fifo_m.size());
    return {46'h0, m_udf, m_ovf, 6'h0, (fifo_m.size() == 16), (fifo_m.size() == 0), 3'h0, lvl};
  endfunction

  task automatic model_reset();
    fifo_m.delete();
    exp_q.delete();
    m_enable = 0; m_thresh = 0; m_scratch = 0; m_ovf_cnt = 0;
    m_ovf = 0; m_udf = 0; m_exp_rd_v = 0; m_exp_fl = 0; m_exp_th = 0;
    exp_hold = 0;
  endtask

  task automatic model_step();
    logic [9:0]  a;
    logic [63:0] rv;
    bit old_en, flush_now, ev_ovf, ev_udf, wr_cnt;
    a         = bus.addr[9:0];
    old_en    = m_enable;
    flush_now = bus.wr_en && (a == 10'h000) && bus.wr_data[1];
    ev_ovf    = 0;
    ev_udf    = 0;
    wr_cnt    = bus.wr_en && (a == 10'h002);
    // threshold flag follows the level the FIFO held before this edge
    m_exp_th  = (m_thresh != 0) && (fifo_m.size() >= int'(m_thresh));
    if (bus.rd_en) begin
      case (a)
        10'h000: rv = {48'h0, m_thresh, 7'h0, m_enable};
        10'h001: rv = m_status();
        10'h002: rv = {32'h0, m_ovf_cnt};
        10'h003: rv = m_scratch;
        10'h004: rv = 64'h5555_AAAA_0000_0007;
        10'h010: begin
          if (fifo_m.size() == 0) begin rv = 64'h0; ev_udf = 1; end
          else rv = fifo_m.pop_front();
        end
        default: rv = {32'hDEAD_BEEF, 22'h0, a};
      endcase
      exp_q.push_back(rv);
    end
    m_exp_rd_v = bus.rd_en;
    if (bus.dat_v && old_en && !flush_now) begin
      if (fifo_m.size() < 16) fifo_m.push_back(bus.dat);
      else ev_ovf = 1;
    end
    if (bus.wr_en) begin
      case (a)
        10'h000: begin m_enable = bus.wr_data[0]; m_thresh = bus.wr_data[15:8]; end
        10'h001: begin
          if (bus.wr_data[16]) m_ovf = 0;
          if (bus.wr_data[17]) m_udf = 0;
        end
        10'h002: m_ovf_cnt = 0;
        10'h003: m_scratch = bus.wr_data;
        default: ;
      endcase
    end
    if (ev_ovf && !wr_cnt && m_ovf_cnt != 32'hFFFF_FFFF) m_ovf_cnt++;
    if (ev_ovf) m_ovf = 1;
    if (ev_udf) m_udf = 1;
    if (flush_now) fifo_m.delete();
    m_exp_fl = flush_now;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- scoreboard compare, every cycle ----------------
  always @(negedge clk) begin
    if (m_exp_rd_v) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL sb_queue: got empty expected queue");
      end else exp_hold = exp_q.pop_front();
    end
    chk("sb_rd_v", {63'h0, bus.rd_data_v}, {63'h0, m_exp_rd_v});
    chk("sb_rd_data", bus.rd_data, exp_hold);
    chk("sb_enable", {63'h0, enable_o}, {63'h0, m_enable});
    chk("sb_flush", {63'h0, flush_o}, {63'h0, m_exp_fl});
    chk("sb_thresh_hit", {63'h0, thresh_hit_o}, {63'h0, m_exp_th});
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mm_write(input logic [13:0] addr, input logic [63:0] data);
    bus.addr = addr; bus.wr_data = data; bus.wr_en = 1'b1;
    cycle();
    bus.wr_en = 1'b0;
  endtask

  task automatic mm_read_chk(input string name, input logic [13:0] addr, input logic [63:0] exp);
    bus.addr = addr; bus.rd_en = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
    chk({name, "_v"}, {63'h0, bus.rd_data_v}, 64'h1);
    chk(name, bus.rd_data, exp);
  endtask

  task automatic push_seq(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      bus.dat_v = 1'b1; bus.dat = 64'(first + i);
      cycle();
    end
    bus.dat_v = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    bus.addr = '0; bus.wr_en = 0; bus.rd_en = 0; bus.wr_data = '0;
    bus.dat_v = 0; bus.dat = '0;
    repeat (3) cycle();
    chk("reset_rd_v", {63'h0, bus.rd_data_v}, 64'h0);
    chk("reset_rd_data", bus.rd_data, 64'h0);
    chk("reset_outs", {61'h0, enable_o, flush_o, thresh_hit_o}, 64'h0);
    rst_n = 1'b1;
    cycle();

    // scratch write/read, data held after the pulse
    mm_write(14'h003, 64'h0123_4567_89AB_CDEF);
    mm_read_chk("scratch", 14'h003, 64'h0123_4567_89AB_CDEF);
    cycle();
    chk("scratch_hold_v", {63'h0, bus.rd_data_v}, 64'h0);
    chk("scratch_hold", bus.rd_data, 64'h0123_4567_89AB_CDEF);

    mm_read_chk("id", 14'h004, 64'h5555_AAAA_0000_0007);
    mm_read_chk("unmapped", 14'h3FF, 64'hDEAD_BEEF_0000_03FF);
    mm_read_chk("addr_hi_ignored", 14'h3C03, 64'h0123_4567_89AB_CDEF);

    // back-to-back reads
    bus.addr = 14'h003; bus.rd_en = 1'b1;
    cycle();
    chk("b2b_first", bus.rd_data, 64'h0123_4567_89AB_CDEF);
    bus.addr = 14'h004;
    cycle();
    bus.rd_en = 1'b0;
    chk("b2b_second_v", {63'h0, bus.rd_data_v}, 64'h1);
    chk("b2b_second", bus.rd_data, 64'h5555_AAAA_0000_0007);

    // fill past full
    mm_write(14'h000, 64'h1);
    push_seq(1, 17);
    mm_read_chk("status_full", 14'h001, 64'h0001_0210);
    mm_read_chk("ovf_cnt_1", 14'h002, 64'h1);
    for (int i = 1; i <= 16; i++) mm_read_chk("pop_order", 14'h010, 64'(i));
    mm_read_chk("status_drained", 14'h001, 64'h0001_0100);

    // underflow and W1C
    mm_read_chk("pop_empty", 14'h010, 64'h0);
    mm_read_chk("status_udf", 14'h001, 64'h0003_0100);
    mm_write(14'h001, 64'h3_0000);
    mm_read_chk("status_w1c", 14'h001, 64'h0000_0100);

    // pushes while disabled are dropped silently
    mm_write(14'h000, 64'h0);
    push_seq(50, 5);
    mm_read_chk("status_disabled", 14'h001, 64'h0000_0100);
    mm_read_chk("ovf_cnt_kept", 14'h002, 64'h1);
    mm_write(14'h002, 64'h0);
    mm_read_chk("ovf_cnt_clr", 14'h002, 64'h0);

    // threshold and flush with concurrent push
    mm_write(14'h000, 64'h0401);
    push_seq(1, 4);
    chk("thresh_lag", {63'h0, thresh_hit_o}, 64'h0);
    cycle();
    chk("thresh_hit", {63'h0, thresh_hit_o}, 64'h1);
    bus.addr = 14'h000; bus.wr_data = 64'h0403; bus.wr_en = 1'b1;
    bus.dat_v = 1'b1; bus.dat = 64'h99;
    cycle();
    bus.wr_en = 1'b0; bus.dat_v = 1'b0;
    chk("flush_pulse", {63'h0, flush_o}, 64'h1);
    cycle();
    chk("flush_done", {63'h0, flush_o}, 64'h0);
    chk("thresh_drop", {63'h0, thresh_hit_o}, 64'h0);
    mm_read_chk("status_flushed", 14'h001, 64'h0000_0100);
    mm_read_chk("ctrl_flush_rd0", 14'h000, 64'h0401);

    // full with simultaneous push and pop
    push_seq(1, 16);
    bus.addr = 14'h010; bus.rd_en = 1'b1; bus.dat_v = 1'b1; bus.dat = 64'h77;
    cycle();
    bus.rd_en = 1'b0; bus.dat_v = 1'b0;
    chk("full_pushpop", bus.rd_data, 64'h1);
    mm_read_chk("status_pushpop", 14'h001, 64'h0000_0210);

    // W1C racing a new overflow: set wins
    bus.addr = 14'h001; bus.wr_data = 64'h1_0000; bus.wr_en = 1'b1;
    bus.dat_v = 1'b1; bus.dat = 64'h88;
    cycle();
    bus.wr_en = 1'b0; bus.dat_v = 1'b0;
    mm_read_chk("status_set_wins", 14'h001, 64'h0001_0210);
    mm_read_chk("ovf_cnt_after", 14'h002, 64'h1);

    // read and write of the same register in one cycle
    bus.addr = 14'h003; bus.wr_data = 64'hFEED; bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    cycle();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    chk("rw_pre_value", bus.rd_data, 64'h0123_4567_89AB_CDEF);
    mm_read_chk("rw_post_value", 14'h003, 64'hFEED);

    // reset in the middle of a read response
    bus.addr = 14'h003; bus.rd_en = 1'b1;
    cycle();
    bus.rd_en = 1'b0;
    chk("pre_reset_v", {63'h0, bus.rd_data_v}, 64'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_rd_v", {63'h0, bus.rd_data_v}, 64'h0);
    chk("midrst_rd_data", bus.rd_data, 64'h0);
    chk("midrst_outs", {61'h0, enable_o, flush_o, thresh_hit_o}, 64'h0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    mm_read_chk("post_rst_ctrl", 14'h000, 64'h0);
    mm_read_chk("post_rst_status", 14'h001, 64'h0000_0100);
    mm_read_chk("post_rst_ovf", 14'h002, 64'h0);
    mm_read_chk("post_rst_scratch", 14'h003, 64'h0);

    repeat (3) cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
